// File: rtl/noc_pkg.sv
// Shared router constants and the switch-allocation state type.
package noc_pkg;

    localparam int unsigned N_PORTS      = 8;
    localparam int unsigned CREDIT_DEPTH = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/sa_out_port_ctrl_if.sv
// Request/grant/credit bundle between the input units and one output-port allocator.
interface sa_out_port_ctrl_if #(
    parameter  int unsigned N_IN    = 8,
    parameter  int unsigned CREDITS = 4,
    localparam int unsigned CW      = $clog2(CREDITS + 1)
);

    logic [N_IN-1:0] req;
    logic [N_IN-1:0] head;
    logic [N_IN-1:0] tail;
    logic            credit_in;
    logic [N_IN-1:0] grant;
    logic            out_valid;
    logic            busy;
    logic [CW-1:0]   credits;
    logic            cr_err;

    modport master (
        output req, head, tail, credit_in,
        input  grant, out_valid, busy, credits, cr_err
    );

    modport slave (
        input  req, head, tail, credit_in,
        output grant, out_valid, busy, credits, cr_err
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of cand at or above the one-hot pointer p, with wrap.
module rr_pick #(
    parameter int unsigned N_IN = 8
) (
    input  logic [N_IN-1:0] cand,
    input  logic [N_IN-1:0] p,
    output logic [N_IN-1:0] pick
);

    logic [2*N_IN-1:0] dbl;
    logic [2*N_IN-1:0] masked;

    // Borrow from p ripples up to the first candidate; the upper copy covers the wrap.
    assign dbl    = {cand, cand};
    assign masked = dbl & ~(dbl - {{N_IN{1'b0}}, p});
    assign pick   = masked[N_IN-1:0] | masked[2*N_IN-1:N_IN];

endmodule

// File: rtl/sa_out_port_ctrl.sv
// Output-port switch allocator: round-robin head arbitration, per-packet lock, credit gating.
module sa_out_port_ctrl
    import noc_pkg::*;
#(
    parameter int unsigned N_IN    = N_PORTS,
    parameter int unsigned CREDITS = CREDIT_DEPTH
) (
    input logic               clk,
    input logic               rstn,
    sa_out_port_ctrl_if.slave bus
);

    localparam int unsigned    CW         = $clog2(CREDITS + 1);
    localparam logic [CW-1:0]  CREDIT_MAX = CW'(CREDITS);

    state_t          state;
    logic [N_IN-1:0] owner;
    logic [N_IN-1:0] ptr;
    logic [CW-1:0]   cnt;
    logic            cr_err_q;

    logic [N_IN-1:0] pick;
    logic [N_IN-1:0] win;
    logic            granted;
    logic            win_tail;

    rr_pick #(.N_IN(N_IN)) u_pick (
        .cand (bus.req & bus.head),
        .p    (ptr),
        .pick (pick)
    );

    always_comb begin
        win = '0;
        if (cnt != '0) begin
            win = (state == ST_IDLE) ? pick : (owner & bus.req);
        end
    end

    assign granted  = |win;
    assign win_tail = |(win & bus.tail);

    assign bus.grant     = rstn ? win : '0;
    assign bus.out_valid = rstn & granted;
    assign bus.busy      = rstn & (state == ST_LOCKED);
    assign bus.credits   = cnt;
    assign bus.cr_err    = cr_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            owner    <= '0;
            ptr      <= N_IN'(1);
            cnt      <= CREDIT_MAX;
            cr_err_q <= 1'b0;
        end else begin
            if (granted) begin
                if (state == ST_IDLE) begin
                    ptr <= {win[N_IN-2:0], win[N_IN-1]};
                    if (!win_tail) begin
                        state <= ST_LOCKED;
                        owner <= win;
                    end
                end else if (win_tail) begin
                    state <= ST_IDLE;
                    owner <= '0;
                end
            end

            // A returned credit with no grant at full depth is a protocol error; count saturates.
            if (granted && !bus.credit_in) begin
                cnt <= cnt - CW'(1);
            end else if (!granted && bus.credit_in) begin
                if (cnt == CREDIT_MAX) begin
                    cr_err_q <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/sa_out_port_ctrl.md
# sa_out_port_ctrl

Per-output-port switch-allocation controller for the non-pipelined wormhole router. It shares one output link among 8 input ports with round-robin fairness, holds the link for a whole packet (head to tail), and gates every grant on downstream credits. One instance sits in front of each crossbar output column and drives that column's select.

## Interface
- N_IN, 8, number of requesting input ports (power of two, ≥2)
- CREDITS, 4, downstream buffer depth in flits (1..15)
- CW, $clog2(CREDITS+1), credit counter width (derived, not overridden)
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- req  in  N_IN  input i has a flit at its buffer head
- head  in  N_IN  flit at input i is a head flit (qualified by req[i])
- tail  in  N_IN  flit at input i is a tail flit (head&tail = single-flit packet)
- credit_in  in  1  one downstream buffer slot freed this cycle
- grant  out  N_IN  one-hot or zero; input i sends its flit through this output this cycle
- out_valid  out  1  |grant
- busy  out  1  packet lock held (state LOCKED)
- credits  out  CW  current credit count
- cr_err  out  1  sticky: credit_in received while credits == CREDITS

## Operation
- State: ST_IDLE, ST_LOCKED; registered owner (one-hot N_IN), pointer p (one-hot N_IN), credit counter, cr_err.
- ST_IDLE: candidates = req & head. If credits > 0 and candidates ≠ 0, grant the first candidate at or after p, scanning upward with wrap-around from bit N_IN-1 to bit 0. Body/tail flits without an owner are never granted.
- ST_IDLE winner with tail = 0 -> ST_LOCKED, owner ← winner. Winner with tail = 1 (single flit) -> stay ST_IDLE.
- Pointer: on any grant issued in ST_IDLE, p ← winner rotated left by one (winner gets lowest priority). p unchanged in ST_LOCKED and on cycles without a grant.
- ST_LOCKED: grant = owner & req when credits > 0, otherwise 0. The head bit is ignored for the owner. Other inputs are never granted.
- ST_LOCKED: a granted flit with tail = 1 -> ST_IDLE, owner cleared. A stall (no req or no credit) holds state indefinitely.
- Credits: −1 on each grant, +1 on credit_in; both in the same cycle -> unchanged.
- credit_in while credits == CREDITS with no grant in that cycle: the count saturates and cr_err is set. cr_err clears only on reset.
- Invariant: credits never underflows, because no grant is issued at 0.

## Timing
- Reset (rstn low, asynchronous): state ST_IDLE, owner 0, p = 1 (bit 0), credits = CREDITS, cr_err 0.
- While rstn is low, grant, out_valid and busy are forced to 0.
- grant/out_valid are combinational from req/head/tail and registered state: zero-cycle allocation latency. The flit crosses in the same cycle.
- State, p and credits update at the rising edge after the grant cycle.
- busy rises the cycle after a multi-flit head grant and falls the cycle after the tail grant.
- Back-to-back packets: after a tail grant, the new head arbitration happens in the very next cycle. There is no bubble.
- credit_in arriving in the same cycle credits == 0 does not enable a grant that cycle. The grant waits one cycle.
- Reset asserted mid-packet: the lock is dropped. The upstream remainder is the input unit's responsibility.

## Structure
- Shared package noc_pkg: N_PORTS (8), CREDIT_DEPTH (4), the state enum {ST_IDLE, ST_LOCKED}.
- Sub-module rr_pick: combinational, inputs cand[N_IN] and p[N_IN], output one-hot pick. It uses the doubled-vector subtract method.
- All sequential logic lives in sa_out_port_ctrl.

## Test plan
- **Round-robin fairness:** after reset, req = head = tail = 8'hFF, credit_in returned every cycle -> grants 01, 02, 04 … 80, 01 on consecutive cycles; busy stays 0.
- **Packet lock:** input 2 sends a 3-flit packet (head, body, tail) while inputs 0 and 5 hold head requests -> grant 04 for three cycles. busy is 1 during the body and tail cycles. The next grant is 20 (p = bit 3, so input 5 is next in scan order).
- **Credit stall:** CREDITS = 4, no credit_in, input 1 sends a 6-flit packet -> 4 grants, then grant 0 with busy = 1. One credit_in -> next cycle grant 02, credits returns to 0.
- **Simultaneous grant and credit_in at credits = 2:** credits stays 2. credit_in with credits = 4 and no grant -> credits stays 4, cr_err = 1 and stays set.
- **Body flit without owner:** in ST_IDLE, req = 8'h08 with head = 0 -> grant 0 indefinitely, p unchanged.
- **Reset mid-packet:** assert rstn low during the body of input 6's packet -> grant, busy go 0 immediately. After release, credits = 4 and p = 01.
